// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state type and constants for the frequency ratio meter.
package freq_meter_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int SYM_TOL = 1;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with single-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic r_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/freq_ratio_meter.sv
// freq_ratio_meter: measures high/low time and period of a slow input in clk cycles.
module freq_ratio_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT = 32'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic             clr_timeout,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             sym_ok,
    output logic             meas_valid,
    output logic             timeout
);
    state_t r_state;
    logic [CNT_W-1:0] r_hcnt, r_lcnt;
    logic w_rise, w_fall, w_tmo, w_sym;
    logic [CNT_W-1:0] w_lim, w_diff;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .i_d(sig_in), .o_rise(w_rise), .o_fall(w_fall)
    );

    // a phase times out on the cycle its counter would reach TIMEOUT, so counters never wrap
    assign w_lim  = CNT_W'(TIMEOUT - 1);
    assign w_tmo  = en && ((r_state == HIGH && !w_fall && r_hcnt >= w_lim) ||
                           (r_state == LOW && !w_rise && r_lcnt >= w_lim));
    assign w_diff = (r_hcnt >= r_lcnt) ? r_hcnt - r_lcnt : r_lcnt - r_hcnt;
    assign w_sym  = w_diff <= CNT_W'(SYM_TOL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hcnt     <= '0;
            r_lcnt     <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            sym_ok     <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= w_tmo ? 1'b1 : (clr_timeout ? 1'b0 : timeout);
            if (!en || w_tmo) begin
                r_state <= IDLE;
                r_hcnt  <= '0;
                r_lcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: if (w_rise) begin
                        r_state <= HIGH;
                        r_hcnt  <= CNT_W'(1);
                    end
                    HIGH: if (w_fall) begin
                        r_state <= LOW;
                        r_lcnt  <= CNT_W'(1);
                    end else r_hcnt <= r_hcnt + 1'b1;
                    LOW: if (w_rise) begin
                        high_cnt   <= r_hcnt;
                        low_cnt    <= r_lcnt;
                        period     <= {1'b0, r_hcnt} + {1'b0, r_lcnt};
                        sym_ok     <= w_sym;
                        meas_valid <= 1'b1;
                        r_state    <= HIGH;
                        r_hcnt     <= CNT_W'(1);
                        r_lcnt     <= '0;
                    end else r_lcnt <= r_lcnt + 1'b1;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_freq_ratio_meter.sv
// tb_freq_ratio_meter: directed vector table plus corner-case sequences.
module tb_freq_ratio_meter;
    logic clk = 1'b0;
    logic rst, en, sig_in, clr_timeout;
    logic [15:0] high_cnt, low_cnt;
    logic [16:0] period;
    logic sym_ok, meas_valid, timeout;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, nvalid = 0, last_cyc = 0, gap = 0;

    freq_ratio_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .clr_timeout(clr_timeout),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period), .sym_ok(sym_ok),
        .meas_valid(meas_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (meas_valid) begin
        nvalid   <= nvalid + 1;
        gap      <= cyc - last_cyc;
        last_cyc <= cyc;
    end

    typedef struct {int h; int l; int n; int eh; int el; int ep; bit es;} vec_t;
    vec_t tbl[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sig_in = 1'b0; clr_timeout = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0;
    endtask

    initial begin
        tbl[0] = '{3, 3, 4, 3, 3, 6, 1'b1};
        tbl[1] = '{2, 3, 3, 2, 3, 5, 1'b1};
        tbl[2] = '{2, 5, 3, 2, 5, 7, 1'b0};
        tbl[3] = '{1, 9, 3, 1, 9, 10, 1'b0};
        tbl[4] = '{4, 4, 2, 4, 4, 8, 1'b1};
        tbl[5] = '{1, 1, 3, 1, 1, 2, 1'b1};
        tbl[6] = '{5, 2, 2, 5, 2, 7, 1'b0};
        rst = 1'b1; en = 1'b0; sig_in = 1'b0; clr_timeout = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("rst high_cnt", 32'(high_cnt), 0);
        check("rst low_cnt", 32'(low_cnt), 0);
        check("rst period", 32'(period), 0);
        check("rst sym_ok", 32'(sym_ok), 0);
        check("rst meas_valid", 32'(meas_valid), 0);
        check("rst timeout", 32'(timeout), 0);

        // n full periods, then a closing rise: n results expected
        for (int i = 0; i < 7; i++) begin
            do_reset();
            en = 1'b1;
            drive(1'b0, 3);
            for (int p = 0; p < tbl[i].n; p++) begin
                drive(1'b1, tbl[i].h);
                drive(1'b0, tbl[i].l);
            end
            drive(1'b1, 1);
            drive(1'b0, 6);
            en = 1'b0;
            drive(1'b0, 2);
            check($sformatf("vec%0d count", i), 32'(nvalid), 32'(tbl[i].n));
            check($sformatf("vec%0d high", i), 32'(high_cnt), 32'(tbl[i].eh));
            check($sformatf("vec%0d low", i), 32'(low_cnt), 32'(tbl[i].el));
            check($sformatf("vec%0d period", i), 32'(period), 32'(tbl[i].ep));
            check($sformatf("vec%0d sym", i), 32'(sym_ok), 32'(tbl[i].es));
            check($sformatf("vec%0d gap", i), 32'(gap), 32'(tbl[i].ep));
            check($sformatf("vec%0d timeout", i), 32'(timeout), 0);
        end

        // timeout: input held high after first rise
        do_reset();
        en = 1'b1;
        drive(1'b0, 3);
        drive(1'b1, 21);
        check("tmo before", 32'(timeout), 0);
        drive(1'b1, 1);
        check("tmo set", 32'(timeout), 1);
        drive(1'b1, 3);
        check("tmo sticky", 32'(timeout), 1);
        check("tmo no valid", 32'(nvalid), 0);
        clr_timeout = 1'b1;
        drive(1'b1, 1);
        clr_timeout = 1'b0;
        check("tmo cleared", 32'(timeout), 0);
        drive(1'b0, 4);
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 4);
            drive(1'b0, 4);
        end
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("tmo resume count", 32'(nvalid), 3);
        check("tmo resume period", 32'(period), 8);
        check("tmo resume flag", 32'(timeout), 0);

        // reset mid-HIGH after a valid result
        drive(1'b1, 2);
        rst = 1'b1;
        sig_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0;
        check("midrst high", 32'(high_cnt), 0);
        check("midrst period", 32'(period), 0);
        check("midrst sym", 32'(sym_ok), 0);
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 3);
        check("midrst no early valid", 32'(nvalid), 0);
        drive(1'b1, 2);
        check("latency pre", 32'(meas_valid), 0);
        drive(1'b1, 1);
        check("latency hit", 32'(meas_valid), 1);
        drive(1'b1, 1);
        check("latency pulse end", 32'(meas_valid), 0);
        drive(1'b0, 6);
        check("midrst count", 32'(nvalid), 1);
        check("midrst new period", 32'(period), 6);

        // en dropped mid-LOW
        do_reset();
        en = 1'b1;
        drive(1'b0, 3);
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 2);
            drive(1'b0, 3);
        end
        drive(1'b1, 4);
        drive(1'b0, 2);
        en = 1'b0;
        drive(1'b0, 5);
        en = 1'b1;
        drive(1'b0, 2);
        check("en count held", 32'(nvalid), 2);
        check("en high held", 32'(high_cnt), 2);
        check("en low held", 32'(low_cnt), 3);
        drive(1'b1, 3);
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 6);
        check("en count new", 32'(nvalid), 3);
        check("en high new", 32'(high_cnt), 3);
        check("en low new", 32'(low_cnt), 3);
        check("en period new", 32'(period), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
